// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: CPU-side register port of the interrupt controller.
//   reg_sel : register select (0=PEND, 1=MASK, 2=CTRL, 3=EOI)
//   wdata   : write data
//   we      : one-cycle write strobe
//   rdata   : combinational read data for reg_sel
// master = CPU side, slave = controller side.
interface irq_ctrl_if;
   logic [1:0]  reg_sel;
   logic [15:0] wdata;
   logic        we;
   logic [15:0] rdata;

   modport master (output reg_sel, output wdata, output we, input rdata);
   modport slave  (input reg_sel, input wdata, input we, output rdata);
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt/trap sequencer in front of the core's irq_r/trap_r inputs.
// Latches rising edges on irq_in into PEND, gates them by MASK and the global
// enable, and presents the lowest-index eligible source while no handler is
// active. The decoder's FETCH state is the acknowledge point; the handler stays
// in service until software writes EOI. Traps are unmaskable and win priority.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   irq_in       : NSRC rising-edge request lines (synchronous to clk)
//   trap_req     : one-cycle trap pulse
//   state        : decoder FSM state, FETCH_ST marks the acknowledge cycle
//   bus          : register port (irq_ctrl_if.slave)
//   irq_r/trap_r : requests to the core
//   irq_vec      : vector of last acknowledged event (7 = trap)
//   in_service   : handler active
module irq_ctrl #(
   parameter int          NSRC     = 4,
   parameter logic [3:0]  FETCH_ST = 4'b0001
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] irq_in,
   input  logic            trap_req,
   input  logic [3:0]      state,
   irq_ctrl_if.slave       bus,
   output logic            irq_r,
   output logic            trap_r,
   output logic [2:0]      irq_vec,
   output logic            in_service
);

   typedef enum logic {IDLE = 1'b0, SERVICE = 1'b1} fsm_t;

   localparam logic [1:0] SEL_PEND = 2'd0;
   localparam logic [1:0] SEL_MASK = 2'd1;
   localparam logic [1:0] SEL_CTRL = 2'd2;
   localparam logic [1:0] SEL_EOI  = 2'd3;

   fsm_t            fsm_q, fsm_d;
   logic [NSRC-1:0] pend_q, pend_d;
   logic [NSRC-1:0] mask_q, mask_d;
   logic [NSRC-1:0] irq_prev_q, irq_prev_d;
   logic            enable_q, enable_d;
   logic            in_service_q, in_service_d;
   logic            trap_pend_q, trap_pend_d;
   logic [2:0]      irq_vec_q, irq_vec_d;

   logic [NSRC-1:0] rise, eligible, pend_clr;
   logic [2:0]      ack_idx;
   logic            fetch, eoi_wr, ack_trap, ack_irq;
   fsm_t            fsm_post_eoi;

   // High data bits are never stored; fold them so they count as consumed.
   logic unused_wdata;
   assign unused_wdata = ^bus.wdata[15:NSRC];

   assign rise     = irq_in & ~irq_prev_q;
   assign eligible = pend_q & mask_q;
   assign fetch    = (state == FETCH_ST);
   assign eoi_wr   = bus.we && (bus.reg_sel == SEL_EOI);

   // EOI is applied before the acknowledge decision, so an EOI and a new
   // acknowledge in the same cycle leave the FSM in SERVICE.
   assign fsm_post_eoi = (eoi_wr && fsm_q == SERVICE) ? IDLE : fsm_q;

   assign trap_r = trap_pend_q;
   assign irq_r  = enable_q & (|eligible) & ~trap_pend_q & (fsm_q == IDLE);

   assign ack_trap = fetch & trap_pend_q;
   assign ack_irq  = fetch & ~trap_pend_q & enable_q & (|eligible) &
                     (fsm_post_eoi == IDLE);

   // Lowest-index eligible source.
   always_comb begin
      ack_idx = 3'd0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (eligible[i]) ack_idx = 3'(i);
      end
   end

   always_comb begin
      fsm_d        = fsm_post_eoi;
      mask_d       = mask_q;
      enable_d     = enable_q;
      irq_vec_d    = irq_vec_q;
      trap_pend_d  = trap_pend_q;
      irq_prev_d   = irq_in;
      pend_clr     = '0;

      if (bus.we) begin
         case (bus.reg_sel)
            SEL_PEND: pend_clr = bus.wdata[NSRC-1:0];
            SEL_MASK: mask_d   = bus.wdata[NSRC-1:0];
            SEL_CTRL: enable_d = bus.wdata[0];
            default:  ;
         endcase
      end

      if (ack_trap) begin
         trap_pend_d = 1'b0;
         irq_vec_d   = 3'd7;
      end else if (ack_irq) begin
         irq_vec_d         = ack_idx;
         pend_clr[ack_idx] = 1'b1;
         fsm_d             = SERVICE;
      end

      // A new pulse outranks a same-cycle acknowledge.
      if (trap_req) trap_pend_d = 1'b1;

      // Rising edges outrank both software clear and acknowledge clear.
      pend_d       = (pend_q & ~pend_clr) | rise;
      in_service_d = (fsm_d == SERVICE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_q        <= IDLE;
         pend_q       <= '0;
         mask_q       <= '0;
         irq_prev_q   <= '0;
         enable_q     <= 1'b0;
         in_service_q <= 1'b0;
         trap_pend_q  <= 1'b0;
         irq_vec_q    <= 3'd0;
      end else begin
         fsm_q        <= fsm_d;
         pend_q       <= pend_d;
         mask_q       <= mask_d;
         irq_prev_q   <= irq_prev_d;
         enable_q     <= enable_d;
         in_service_q <= in_service_d;
         trap_pend_q  <= trap_pend_d;
         irq_vec_q    <= irq_vec_d;
      end
   end

   always_comb begin
      bus.rdata = 16'd0;
      case (bus.reg_sel)
         SEL_PEND: bus.rdata = 16'(pend_q);
         SEL_MASK: bus.rdata = 16'(mask_q);
         SEL_CTRL: bus.rdata = {10'd0, trap_pend_q, irq_vec_q, in_service_q, enable_q};
         default:  bus.rdata = 16'd0;
      endcase
   end

   assign irq_vec    = irq_vec_q;
   assign in_service = in_service_q;

endmodule
